// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_STEP = 4;
  localparam int XLEN    = 32;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Redirect, instruction-memory and core-side delivery signals of the fetch stage.
interface fetch_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             mem_req;
  logic [DEPTH-3:0] mem_addr;
  logic             mem_ready;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_ready, mem_rvalid, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_ready, mem_rvalid, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer; flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter type entry_t    = fetch_entry_t,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  entry_t  push_data,
  input  logic    pop,
  input  logic    flush,
  output logic [AW:0] count,
  output entry_t  head
);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  entry_t        slot_reg [FIFO_DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_reg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads zero before the first push.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_reg[gi] <= '0;
      end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
        slot_reg[gi] <= push_data;
      end
    end
  end

  assign count = count_reg;
  assign head  = slot_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps one memory request in flight and buffers
// returned words with their PCs; a redirect flushes the buffer and any pending reply.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 16,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  fetch_state_t     state_reg, state_next;
  logic [WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [WIDTH-1:0] req_pc_reg, req_pc_next;
  logic             push, pop, flush;
  logic [CW-1:0]    count;
  entry_t           head, push_entry;

  assign push_entry = '{pc: req_pc_reg, instr: bus.mem_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    bus.mem_req   = 1'b0;
    push          = 1'b0;
    flush         = 1'b0;
    if (bus.redirect_valid) begin
      // A reply still owed for the old path must be swallowed in DROP.
      flush         = 1'b1;
      fetch_pc_next = bus.redirect_pc & ~WIDTH'(3);
      unique case (state_reg)
        FETCH:   state_next = FETCH;
        WAIT:    state_next = bus.mem_rvalid ? FETCH : DROP;
        DROP:    state_next = bus.mem_rvalid ? FETCH : DROP;
        default: state_next = FETCH;
      endcase
    end else begin
      unique case (state_reg)
        FETCH: begin
          bus.mem_req = (count < CW'(FIFO_DEPTH)) && !rst;
          if (bus.mem_req && bus.mem_ready) begin
            req_pc_next   = fetch_pc_reg;
            fetch_pc_next = fetch_pc_reg + WIDTH'(PC_STEP);
            state_next    = WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            push       = 1'b1;
            state_next = FETCH;
          end
        end
        DROP: begin
          if (bus.mem_rvalid) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.mem_addr  = fetch_pc_reg[DEPTH-1:2];

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .entry_t    (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle core's decode/execute path.
- Owns the fetch PC and issues word requests to instruction memory over a req/ready + rvalid handshake.
- Buffers returned instructions, each paired with its PC, in a small FIFO.
- Delivers them to the core over a valid/ready interface.
- Handles control-flow redirects from branch/jal/jalr resolution by flushing buffered and in-flight fetches.

Parameters:
- WIDTH, 32: data and PC width in bits.
- DEPTH, 16: instruction memory byte-address bits; word address is pc[DEPTH-1:2].
- FIFO_DEPTH, 4: instruction buffer entries; power of two, at least 2.
- RESET_PC, 0: fetch PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect_valid  in  1  core requests a fetch redirect this cycle.
- redirect_pc  in  WIDTH  new fetch PC; bits [1:0] are ignored and treated as 0.
- mem_req  out  1  fetch request valid.
- mem_addr  out  DEPTH-2  word address, equal to fetch_pc[DEPTH-1:2].
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid; at most one response per accepted request, arriving one or more cycles after acceptance.
- mem_rdata  in  WIDTH  instruction word.
- out_valid  out  1  buffered instruction available.
- out_ready  in  1  core consumes the instruction.
- out_instr  out  WIDTH  instruction at the FIFO head.
- out_pc  out  WIDTH  PC of out_instr.

Behaviour:
- Reset (asynchronous, any state):
  - state=FETCH, fetch_pc=RESET_PC, req_pc=0, FIFO count=0, all FIFO storage 0.
  - Outputs: mem_req=0, out_valid=0, out_instr=0, out_pc=0, mem_addr=RESET_PC[DEPTH-1:2].
  - mem_req is forced to 0 while rst is high.
- State machine, with at most one outstanding memory request:
  - FETCH:
    - mem_req=1 when count<FIFO_DEPTH and !redirect_valid.
    - On mem_req&&mem_ready: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^WIDTH wrap), go to WAIT.
    - mem_rvalid in FETCH is ignored; this covers stale responses after reset.
  - WAIT:
    - mem_req=0.
    - On mem_rvalid: push {req_pc, mem_rdata}, go to FETCH.
  - DROP:
    - mem_req=0.
    - On mem_rvalid: discard the data, go to FETCH.
- Redirect, which has priority over every other event in the same cycle:
  - FIFO is flushed (count<=0) and fetch_pc<=redirect_pc with [1:0] cleared.
  - From FETCH: stay in FETCH; no request is issued in the redirect cycle.
  - From WAIT, without mem_rvalid: go to DROP.
  - From WAIT, with mem_rvalid: data discarded, go to FETCH.
  - From DROP, without mem_rvalid: stay in DROP.
  - From DROP, with mem_rvalid: go to FETCH.
  - An out_valid&&out_ready transfer in the redirect cycle counts as completed; out_valid is 0 the next cycle.
- Output handshake:
  - out_valid = (count!=0).
  - out_instr and out_pc are combinational from the head entry.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop keeps count unchanged.
  - While out_valid=1 and out_ready=0, out_instr and out_pc hold stable.
- Full FIFO:
  - No request is issued when count==FIFO_DEPTH.
  - Because issue requires count<FIFO_DEPTH and only one request is outstanding, a push never overflows.
- Latency and throughput:
  - With mem_ready=1 and rvalid one cycle after acceptance: request in cycle N, push in N+1, out_valid=1 in N+2.
  - Steady-state throughput is one instruction per 2 cycles.
- Empty FIFO: out_instr and out_pc show the head slot contents; out_valid=0 marks them don't-care.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {FETCH, WAIT, DROP}.
  - fetch_entry_t packed struct {pc, instr}, each WIDTH bits.
  - Constant PC_STEP=4.
- Sub-module fetch_fifo:
  - Parameterised on FIFO_DEPTH and entry type.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push and pop.
  - Asynchronous active-high reset.

Test Plan:
- Reset, then mem_ready=1, rvalid one cycle later, mem_rdata=0x00500093, out_ready=1 -> mem_addr=0 at cycle 0; out_valid=1 at cycle 2 with out_pc=0x0, out_instr=0x00500093; next out_pc=0x4, 0x8, in order.
- out_ready=0 with instant memory -> exactly 4 instructions buffered (PCs 0x0, 0x4, 0x8, 0xC); mem_req=0 once full; raise out_ready -> drained in order, fetching resumes at 0x10.
- Redirect to 0x40 while in WAIT for PC 0x8, rvalid arriving 2 cycles later -> response discarded; FIFO empty; next mem_addr=0x10 (word); first delivered out_pc=0x40.
- redirect_pc=0x46 in the same cycle as mem_rvalid and a pop -> data dropped, state FETCH, fetch_pc=0x44, out_valid=0 next cycle.
- rst asserted mid-WAIT, then stale mem_rvalid after release -> all outputs 0 during reset; stale rvalid ignored; first fetch at RESET_PC.
- RESET_PC=0xFFFFFFFC -> fetch of 0xFFFFFFFC, then wrap to 0x00000000 with out_pc values in that order.
